// File: rtl/color_fill_controller.sv
// Register-programmed rectangle fill of the color-cell area of a frame buffer, one cell per accepted write.
// Define COLOR_CLIP_EN to clip rectangles to the cell grid instead of rejecting them with an error.
module color_fill_controller #(
    parameter int CELLS_X     = 40,
    parameter int CELLS_Y     = 25,
    parameter int DATA_OFFSET = 8000,
    parameter int ADDR_W      = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              device_select,
    input  logic [3:0]        register_offset,
    input  logic              write_req,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              fb_write_enable,
    input  logic              fb_ready,
    output logic              clear_request,
    input  logic              clear_in_progress,
    output logic              busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    localparam logic [3:0] REG_VALUES  = 4'hC;
    localparam logic [3:0] REG_ORIGIN  = 4'hD;
    localparam logic [3:0] REG_EXTENT  = 4'hE;
    localparam logic [3:0] REG_CONTROL = 4'hF;

    logic [0:0]        state_q, state_d;
    logic [15:0]       values_q, values_d;
    logic [15:0]       origin_q, origin_d;
    logic [15:0]       extent_q, extent_d;
    logic              error_q, error_d;
    logic              clear_q, clear_d;
    logic [7:0]        color_q, color_d;
    logic [7:0]        x0_q, x0_d;
    logic [7:0]        x_end_q, x_end_d;
    logic [7:0]        y_end_q, y_end_d;
    logic [7:0]        cur_x_q, cur_x_d;
    logic [7:0]        cur_y_q, cur_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;

    logic              wr_ok;
    logic [7:0]        cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [8:0]        x_last, y_last;
    logic              origin_bad, cmd_reject;
    logic [7:0]        cmd_x_end, cmd_y_end;
    logic [ADDR_W-1:0] cmd_addr;
    logic              unused_wdata;

    assign busy            = (state_q == FILL);
    assign fb_write_enable = (state_q == FILL) && !clear_in_progress;
    assign fb_addr         = addr_q;
    assign fb_data         = color_q;
    assign clear_request   = clear_q;
    assign unused_wdata    = ^{wdata[14:12], wdata[10], wdata[7:0]};

    assign wr_ok = write_req && device_select && !busy && !clear_in_progress;

    // Put is a 1x1 fill at ORIGIN; it wins over Fill when both bits are set.
    assign cmd_x0     = origin_q[7:0];
    assign cmd_y0     = origin_q[15:8];
    assign cmd_w      = wdata[8] ? 8'd1 : extent_q[7:0];
    assign cmd_h      = wdata[8] ? 8'd1 : extent_q[15:8];
    assign x_last     = {1'b0, cmd_x0} + {1'b0, cmd_w} - 9'd1;
    assign y_last     = {1'b0, cmd_y0} + {1'b0, cmd_h} - 9'd1;
    assign origin_bad = ({1'b0, cmd_x0} >= 9'(CELLS_X)) || ({1'b0, cmd_y0} >= 9'(CELLS_Y));
    assign cmd_addr   = ADDR_W'(DATA_OFFSET) + ADDR_W'(cmd_y0) * ADDR_W'(CELLS_X) + ADDR_W'(cmd_x0);

`ifdef COLOR_CLIP_EN
    assign cmd_reject = origin_bad;
    assign cmd_x_end  = (x_last > 9'(CELLS_X - 1)) ? 8'(CELLS_X - 1) : x_last[7:0];
    assign cmd_y_end  = (y_last > 9'(CELLS_Y - 1)) ? 8'(CELLS_Y - 1) : y_last[7:0];
`else
    assign cmd_reject = origin_bad || (x_last >= 9'(CELLS_X)) || (y_last >= 9'(CELLS_Y));
    assign cmd_x_end  = x_last[7:0];
    assign cmd_y_end  = y_last[7:0];
`endif

    always_comb begin
        rdata = 16'h0000;
        if (device_select) begin
            case (register_offset)
                REG_VALUES:  rdata = values_q;
                REG_ORIGIN:  rdata = origin_q;
                REG_EXTENT:  rdata = extent_q;
                REG_CONTROL: rdata = {14'b0, error_q, busy};
                default:     rdata = 16'h0000;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        values_d   = values_q;
        origin_d   = origin_q;
        extent_d   = extent_q;
        error_d    = error_q;
        clear_d    = 1'b0;
        color_d    = color_q;
        x0_d       = x0_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        addr_d     = addr_q;
        row_addr_d = row_addr_q;

        if (wr_ok) begin
            case (register_offset)
                REG_VALUES: values_d = wdata;
                REG_ORIGIN: origin_d = wdata;
                REG_EXTENT: extent_d = wdata;
                REG_CONTROL: begin
                    if (wdata[15]) error_d = 1'b0;
                    if (wdata[11]) begin
                        clear_d = 1'b1;
                    end else if ((wdata[8] || wdata[9]) && cmd_w != 8'd0 && cmd_h != 8'd0) begin
                        if (cmd_reject) begin
                            error_d = 1'b1;
                        end else begin
                            state_d    = FILL;
                            color_d    = values_q[15:8];
                            x0_d       = cmd_x0;
                            x_end_d    = cmd_x_end;
                            y_end_d    = cmd_y_end;
                            cur_x_d    = cmd_x0;
                            cur_y_d    = cmd_y0;
                            addr_d     = cmd_addr;
                            row_addr_d = cmd_addr;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Row-major scan; the row base tracks (x0, y) so a wrap is one add of CELLS_X.
        if (state_q == FILL && fb_write_enable && fb_ready) begin
            if (cur_x_q == x_end_q) begin
                if (cur_y_q == y_end_q) begin
                    state_d = IDLE;
                end else begin
                    cur_x_d    = x0_q;
                    cur_y_d    = cur_y_q + 8'd1;
                    row_addr_d = row_addr_q + ADDR_W'(CELLS_X);
                    addr_d     = row_addr_q + ADDR_W'(CELLS_X);
                end
            end else begin
                cur_x_d = cur_x_q + 8'd1;
                addr_d  = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            values_q   <= '0;
            origin_q   <= '0;
            extent_q   <= '0;
            error_q    <= 1'b0;
            clear_q    <= 1'b0;
            color_q    <= '0;
            x0_q       <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            addr_q     <= '0;
            row_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            values_q   <= values_d;
            origin_q   <= origin_d;
            extent_q   <= extent_d;
            error_q    <= error_d;
            clear_q    <= clear_d;
            color_q    <= color_d;
            x0_q       <= x0_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            addr_q     <= addr_d;
            row_addr_q <= row_addr_d;
        end
    end
endmodule

// File: doc/color_fill_controller.md
COLOR_FILL_CONTROLLER -- requirements
Module: color_fill_controller

Interface
REQ-001 SHALL have parameter CELLS_X, default 40, meaning color cells per row (1..255).
REQ-002 SHALL have parameter CELLS_Y, default 25, meaning color cell rows (1..255).
REQ-003 SHALL have parameter DATA_OFFSET, default 8000, meaning byte address of cell (0,0).
REQ-004 SHALL have parameter ADDR_W, default 14, meaning frame-buffer address width; DATA_OFFSET+CELLS_X*CELLS_Y SHALL fit in ADDR_W bits.
REQ-005 SHALL have the following ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- device_select  in  1  pre-qualified register select.
- register_offset  in  4  register index.
- write_req  in  1  register write strobe.
- wdata  in  16  write data.
- rdata  out  16  read data (combinational).
- fb_addr  out  ADDR_W  cell byte address.
- fb_data  out  8  color byte.
- fb_write_enable  out  1  write valid.
- fb_ready  in  1  frame buffer accepts write this cycle.
- clear_request  out  1  one-cycle color-clear pulse.
- clear_in_progress  in  1  main module clearing.
- busy  out  1  draw command active.

Function
REQ-006 SHALL accept a register write only when write_req && device_select && !busy && !clear_in_progress; otherwise the write SHALL be dropped.
REQ-007 SHALL implement the following registers:
- 0xC VALUES: R/W 16b; color byte = [15:8].
- 0xD ORIGIN: R/W; X=[7:0], Y=[15:8].
- 0xE EXTENT: R/W; W=[7:0], H=[15:8].
- 0xF CONTROL/STATUS: write bit8=Put, bit9=Fill, bit11=Clear, bit15=clear error; read {14'b0, error, busy}.
REQ-008 SHALL read rdata as don't-care for other offsets or when device_select is low.
REQ-009 SHALL treat Put as Fill with W=H=1 at ORIGIN; Put SHALL have priority when Put and Fill are both set.
REQ-010 SHALL, when bit11 is set, pulse clear_request for exactly one cycle after the write and discard any Put/Fill in the same write.
REQ-011 SHALL treat W=0 or H=0 as a no-op, with no busy and no error.
REQ-012 SHALL, when origin X>=CELLS_X or Y>=CELLS_Y, ignore the command and set sticky error.
REQ-013 SHALL use FSM IDLE->FILL on an accepted command; busy SHALL rise the cycle after the accepting write and SHALL be high exactly while in FILL.
REQ-014 SHALL, in FILL, drive fb_write_enable=1, fb_addr=DATA_OFFSET+y*CELLS_X+x and fb_data=VALUES[15:8], with no overflow in ADDR_W.
REQ-015 SHALL advance a cell only on a cycle with fb_write_enable && fb_ready; otherwise addr and data SHALL stay stable.
REQ-016 SHALL scan row-major: x runs x0..x_end, then wraps to x0 with y+1; after (x_end,y_end) is accepted it SHALL return to IDLE next cycle.
REQ-017 SHALL sustain one cell per cycle when fb_ready=1 and SHALL write no cell twice.
REQ-018 SHALL, while clear_in_progress=1 in FILL, drop fb_write_enable and hold position, then resume when it is released.
REQ-019 SHALL hold VALUES/ORIGIN/EXTENT in snapshot registers for the duration of the command.

Reset
REQ-020 SHALL, while reset is high, force all registers to 0, FSM to IDLE, error to 0, and fb_addr, fb_data, fb_write_enable, clear_request and busy to 0, regardless of clk.
REQ-021 SHALL abandon a fill when reset asserts mid-command, with no further writes after release.

Configuration
REQ-022 SHALL, with COLOR_CLIP_EN defined, clip the rectangle to x_end=min(x0+W-1,CELLS_X-1) and y_end=min(y0+H-1,CELLS_Y-1) without setting error.
REQ-023 SHALL, without COLOR_CLIP_EN, ignore a command with any cell out of range and set error.

Verification
REQ-024 SHALL cover: ORIGIN=0x1827 (39,24), CONTROL=0x0100 -> single write at addr 8999 with data VALUES[15:8]; busy high for 1 cycle.
REQ-025 SHALL cover: ORIGIN=0x0102, EXTENT=0x0203, Fill, fb_ready=1 -> addrs 8042,8043,8044,8082,8083,8084 on consecutive cycles.
REQ-026 SHALL cover: ORIGIN=0x0026, EXTENT=0x0104 -> with COLOR_CLIP_EN, writes 8038 and 8039 only; without it, no writes and status reads 0x0002.
REQ-027 SHALL cover: fb_ready low for 3 cycles mid-fill -> addr held stable, no skipped or duplicated cell; a register write during busy is ignored.
REQ-028 SHALL cover: CONTROL=0x0900 -> one-cycle clear_request and no fill; reset asserted mid-fill -> fb_write_enable low immediately and busy=0.
